sync_debounce_edge: RTL and testbench
=====================================

Name: sync_debounce_edge

Overview:
- Consumer stage for the single-bit flopped signal produced by the lab D-flip-flop stage, for example a button or switch line feeding the lab CPU.
- Synchronises an asynchronous 1-bit input into the `clk` domain and debounces it with a stability counter.
- Emits the clean level plus one-cycle rise and fall strobes, and keeps a wrap-around count of rising edges.
- Downstream logic consumes the strobes as single-cycle events.

Parameters:
- DEB_CYC, 4: consecutive cycles the synchronised input must differ from `y` before `y` changes. Legal range is ≥1; a value of 0 is a fatal elaboration error.
- CNT_W, 8: width of the `rise_cnt` event counter.
- DBW, 3: width of the internal debounce counter. It must satisfy 2^DBW ≥ DEB_CYC.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- a, input, 1: raw asynchronous input level.
- clr, input, 1: synchronous clear of `rise_cnt`.
- y, output, 1: debounced level, registered.
- rise, output, 1: one-cycle strobe when `y` goes 0→1, registered.
- fall, output, 1: one-cycle strobe when `y` goes 1→0, registered.
- rise_cnt, output, CNT_W: number of `rise` strobes since reset or last `clr`, registered.

Behaviour:
- Reset (`rst` = 1, asynchronous): s1, s2, `y`, `rise`, `fall`, debounce count and `rise_cnt` all go to 0 immediately and stay there while `rst` is held.
- Reset release: registers begin updating on the first `clk` rising edge after `rst` falls.
- Synchroniser: s1 <= a; s2 <= s1. This gives 2 edges of latency; only s2 is used downstream.
- Debounce, evaluated every edge:
  - If s2 == `y`: count <= 0.
  - Else if count == DEB_CYC-1: `y` <= s2 and count <= 0.
  - Else: count <= count+1.
- A glitch on s2 shorter than DEB_CYC cycles never changes `y`. Any return of s2 to `y` restarts the count from 0.
- End-to-end latency: `a` changes and is sampled at edge k → s2 valid after edge k+1 → `y` updates at edge k+1+DEB_CYC. With DEB_CYC = 4 this is 6 edges from first sample to `y`.
- Strobes:
  - `rise` and `fall` are high for exactly the one cycle that follows the edge at which `y` changes, i.e. they are coincident with the new `y` value.
  - They are mutually exclusive and are 0 in every other cycle.
- rise_cnt:
  - Increments by 1 at the same edge `y` goes 0→1.
  - Wraps from 2^CNT_W-1 to 0.
  - `clr` = 1 at an edge forces `rise_cnt` to 0.
  - If `clr` and a rising transition occur at the same edge, `clr` wins: `rise_cnt` = 0. `rise` still pulses.
- DEB_CYC = 1: `y` follows s2 one edge later, so `y` changes 3 edges after `a` is first sampled.
- Reset mid-debounce: the pending count is discarded. After release, a new full DEB_CYC window is required.

Decomposition:
- Shared package (e.g. lab_pkg) holds the DEB_CYC and CNT_W defaults and the DBW derivation expression, so neighbouring stages agree.
- One natural sub-module, sync_2ff: the s1/s2 pair with `clk`, `rst`, `d` and `q`, reusable by other asynchronous inputs.
- Debounce, strobe and counter logic stays in the top module.

Test Plan:
- Reset: hold `rst` = 1 for 21 ns with `a` = 1 (T_CLK = 10 ns) → `y`, `rise`, `fall`, `rise_cnt` are all 0 throughout; after release `y` = 1 by the 6th edge, `rise` pulses once, `rise_cnt` = 1.
- Clean step: `a` 0→1 at a negedge, held 100 ns, DEB_CYC = 4 → `y` rises at the 6th posedge after sampling; `rise` = 1 for exactly 10 ns; `rise_cnt` = 1. Then `a` 1→0 → `fall` pulses once and `rise_cnt` stays 1.
- Glitch rejection: `a` = 1 for 20 ns, then 0 → `y` stays 0, no strobes. Also `a` = 1 for 30 ns, 0 for 10 ns, 1 for 50 ns → `y` rises only after the last segment has been stable for 4 cycles of s2.
- Counter wrap and clear, CNT_W = 2: 4 clean pulses → `rise_cnt` goes 1, 2, 3, 0. Assert `clr` on the same edge as the 5th rise → `rise_cnt` = 0 and `rise` = 1.
- Reset mid-operation: assert `rst` for 5 ns asynchronously (between edges) while the count is at 2 with s2 = 1 → all outputs are 0 at once; after release `y` needs a full 4-cycle window again (6 edges from first sample).
- DEB_CYC = 1 build: `a` step → `y` changes 3 edges after first sample; a 10 ns one-cycle pulse on `a` produces a `y` pulse one cycle wide.

Source files
------------

// File: rtl/sync_debounce_edge_pkg.sv
// Shared defaults for the debounced input stages so neighbouring blocks agree
// on window length, event-counter width and debounce-counter sizing.
package sync_debounce_edge_pkg;

    localparam int DEB_CYC_DEF = 4;
    localparam int CNT_W_DEF   = 8;

    // The debounce counter only ever holds 0..DEB_CYC-1, but one spare bit of
    // headroom keeps 2**DBW >= DEB_CYC for every legal window length.
    function automatic int dbw_for(input int deb_cyc);
        return (deb_cyc <= 1) ? 1 : $clog2(deb_cyc + 1);
    endfunction

    localparam int DBW_DEF = dbw_for(DEB_CYC_DEF);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; only q may be used downstream.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_reg;
    logic [W-1:0] s2_reg;

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        // Each bit gets its own independent metastability-settling pair.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_reg[gi] <= 1'b0;
                s2_reg[gi] <= 1'b0;
            end else begin
                s1_reg[gi] <= d[gi];
                s2_reg[gi] <= s1_reg[gi];
            end
        end
    end

    assign q = s2_reg;

endmodule

// File: rtl/sync_debounce_edge.sv
// Synchronise a raw async level, debounce it with a stability window, and
// produce registered rise/fall strobes plus a wrap-around rising-edge count.
import sync_debounce_edge_pkg::*;

module sync_debounce_edge #(
    parameter int DEB_CYC = DEB_CYC_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DBW     = dbw_for(DEB_CYC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             clr,
    output logic             y,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] rise_cnt
);

    // Reject illegal builds at elaboration rather than silently misbehaving.
    if (DEB_CYC < 1) begin : g_bad_deb_cyc
        $fatal(1, "sync_debounce_edge: DEB_CYC must be >= 1");
    end
    if ((2 ** DBW) < DEB_CYC) begin : g_bad_dbw
        $fatal(1, "sync_debounce_edge: DBW too narrow for DEB_CYC");
    end

    localparam logic [DBW-1:0] CNT_LAST = DBW'(DEB_CYC - 1);

    logic             s2;
    logic [DBW-1:0]   count_reg, count_next;
    logic             y_reg, y_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;
    logic [CNT_W-1:0] rise_cnt_reg, rise_cnt_next;

    sync_2ff #(
        .W (1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (a),
        .q   (s2)
    );

    // Debounce window, strobe generation and event counter next-state.
    always_comb begin
        count_next    = count_reg;
        y_next        = y_reg;
        rise_next     = 1'b0;
        fall_next     = 1'b0;
        rise_cnt_next = rise_cnt_reg;

        if (s2 == y_reg) begin
            // Any return to the current level restarts the window.
            count_next = '0;
        end else if (count_reg == CNT_LAST) begin
            y_next     = s2;
            count_next = '0;
        end else begin
            count_next = count_reg + 1'b1;
        end

        rise_next = y_next & ~y_reg;
        fall_next = ~y_next & y_reg;

        // Clear dominates a simultaneous rising edge; the strobe still fires.
        if (clr) begin
            rise_cnt_next = '0;
        end else if (rise_next) begin
            rise_cnt_next = rise_cnt_reg + 1'b1;
        end
    end

    // State register; reset discards any partially accumulated window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg    <= '0;
            y_reg        <= 1'b0;
            rise_reg     <= 1'b0;
            fall_reg     <= 1'b0;
            rise_cnt_reg <= '0;
        end else begin
            count_reg    <= count_next;
            y_reg        <= y_next;
            rise_reg     <= rise_next;
            fall_reg     <= fall_next;
            rise_cnt_reg <= rise_cnt_next;
        end
    end

    assign y        = y_reg;
    assign rise     = rise_reg;
    assign fall     = fall_reg;
    assign rise_cnt = rise_cnt_reg;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Bench for sync_debounce_edge: three builds (default, CNT_W=2, DEB_CYC=1)
// share stimulus and are checked against directed expectations and a
// history-window reference model.
module tb_sync_debounce_edge;

    logic clk = 1'b0;
    logic rst;
    logic a;
    logic clr;

    logic       y0, r0, f0;
    logic [7:0] c0;
    logic       y1, r1, f1;
    logic [1:0] c1;
    logic       y2, r2, f2;
    logic [7:0] c2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_debounce_edge dut (
        .clk (clk), .rst (rst), .a (a), .clr (clr),
        .y (y0), .rise (r0), .fall (f0), .rise_cnt (c0)
    );

    sync_debounce_edge #(.CNT_W (2)) dut_c2 (
        .clk (clk), .rst (rst), .a (a), .clr (clr),
        .y (y1), .rise (r1), .fall (f1), .rise_cnt (c1)
    );

    sync_debounce_edge #(.DEB_CYC (1)) dut_d1 (
        .clk (clk), .rst (rst), .a (a), .clr (clr),
        .y (y2), .rise (r2), .fall (f2), .rise_cnt (c2)
    );

    // Reference model: keep the history of sampled 'a'. The level seen by the
    // debouncer at an edge is 'a' from two samples back; the output flips when
    // the last DEB_CYC such levels all differ from the current output.
    localparam int NI = 3;
    int dcyc [NI] = '{4, 4, 1};
    int cmod [NI] = '{256, 4, 256};
    bit ah [0:7];
    int my [NI];
    int mr [NI];
    int mf [NI];
    int mc [NI];

    always @(posedge clk or posedge rst) begin : model
        bit nh [0:7];
        bit flip;
        int ny;
        if (rst) begin
            for (int i = 0; i < 8; i++) ah[i] <= 1'b0;
            for (int n = 0; n < NI; n++) begin
                my[n] <= 0; mr[n] <= 0; mf[n] <= 0; mc[n] <= 0;
            end
        end else begin
            nh[0] = a;
            for (int i = 1; i < 8; i++) nh[i] = ah[i-1];
            ah <= nh;
            for (int n = 0; n < NI; n++) begin
                flip = 1'b1;
                for (int j = 0; j < dcyc[n]; j++)
                    if (int'(nh[2+j]) == my[n]) flip = 1'b0;
                ny = flip ? 1 - my[n] : my[n];
                my[n] <= ny;
                mr[n] <= (flip && ny == 1) ? 1 : 0;
                mf[n] <= (flip && ny == 0) ? 1 : 0;
                if (clr) mc[n] <= 0;
                else if (flip && ny == 1) mc[n] <= (mc[n] + 1) % cmod[n];
            end
        end
    end

    task automatic test_reset();
        int nrise;
        #3;
        n_cmp++;
        if ({y0, r0, f0} !== 3'b000 || c0 !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_t3 got y/r/f=%b%b%b cnt=%0d want 000 cnt=0", y0, r0, f0, c0);
        end
        #9;
        n_cmp++;
        if ({y0, r0, f0} !== 3'b000 || c0 !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_t12 got y/r/f=%b%b%b cnt=%0d want 000 cnt=0", y0, r0, f0, c0);
        end
        #8;
        n_cmp++;
        if ({y0, r0, f0} !== 3'b000 || c0 !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_t20 got y/r/f=%b%b%b cnt=%0d want 000 cnt=0", y0, r0, f0, c0);
        end
        #1 rst = 1'b0;
        nrise = 0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (r0 === 1'b1) nrise++;
            if (e == 5) begin
                n_cmp++;
                if (y0 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_early_y edge=5 got %b want 0", y0);
                end
            end
            if (e == 6) begin
                n_cmp++;
                if (y0 !== 1'b1 || r0 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL reset_rise edge=6 got y=%b rise=%b want 1/1", y0, r0);
                end
            end
        end
        n_cmp++;
        if (nrise != 1 || c0 !== 8'd1) begin
            n_bad++;
            $display("FAIL reset_count got pulses=%0d cnt=%0d want 1/1", nrise, c0);
        end
    endtask

    task automatic test_clean_step();
        int base;
        int nrise;
        int nfall;
        a = 1'b0;
        repeat (12) @(negedge clk);
        base = mc[0];
        a = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            n_cmp++;
            if (y0 !== (e >= 6) || r0 !== (e == 6) || f0 !== 1'b0) begin
                n_bad++;
                $display("FAIL step_up edge=%0d got y/r/f=%b%b%b want %b%b0",
                         e, y0, r0, f0, (e >= 6), (e == 6));
            end
        end
        n_cmp++;
        if (c0 !== 8'((base + 1) % 256)) begin
            n_bad++;
            $display("FAIL step_cnt got %0d want %0d", c0, (base + 1) % 256);
        end
        a = 1'b0;
        nrise = 0;
        nfall = 0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (f0 === 1'b1) nfall++;
            if (r0 === 1'b1) nrise++;
        end
        n_cmp++;
        if (nfall != 1 || nrise != 0 || y0 !== 1'b0 || c0 !== 8'((base + 1) % 256)) begin
            n_bad++;
            $display("FAIL step_down got falls=%0d rises=%0d y=%b cnt=%0d want 1/0/0/%0d",
                     nfall, nrise, y0, c0, (base + 1) % 256);
        end
    endtask

    task automatic test_glitch();
        a = 1'b0;
        repeat (12) @(negedge clk);
        a = 1'b1;
        repeat (2) @(negedge clk);
        a = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            n_cmp++;
            if ({y0, r0, f0} !== 3'b000) begin
                n_bad++;
                $display("FAIL glitch_short cyc=%0d got y/r/f=%b%b%b want 000", e, y0, r0, f0);
            end
        end
        a = 1'b1;
        repeat (3) @(negedge clk);
        a = 1'b0;
        @(negedge clk);
        a = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            n_cmp++;
            if (y0 !== (e >= 6) || r0 !== (e == 6)) begin
                n_bad++;
                $display("FAIL glitch_restart edge=%0d got y=%b rise=%b want %b/%b",
                         e, y0, r0, (e >= 6), (e == 6));
            end
        end
        a = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        a = 1'b0;
        repeat (12) @(negedge clk);
        a = 1'b1;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({y0, r0, f0} !== 3'b000 || c0 !== 8'd0) begin
            n_bad++;
            $display("FAIL rstmid_async got y/r/f=%b%b%b cnt=%0d want 000 cnt=0", y0, r0, f0, c0);
        end
        #4 rst = 1'b0;
        @(negedge clk);
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            n_cmp++;
            if (y0 !== (e >= 6) || r0 !== (e == 6)) begin
                n_bad++;
                $display("FAIL rstmid_window edge=%0d got y=%b rise=%b want %b/%b",
                         e, y0, r0, (e >= 6), (e == 6));
            end
        end
        a = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_wrap_clear();
        a   = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int p = 1; p <= 4; p++) begin
            a = 1'b1;
            repeat (8) @(negedge clk);
            n_cmp++;
            if (c1 !== 2'(p % 4)) begin
                n_bad++;
                $display("FAIL wrap pulse=%0d got cnt=%0d want %0d", p, c1, p % 4);
            end
            a = 1'b0;
            repeat (8) @(negedge clk);
        end
        a = 1'b1;
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_cmp++;
        if (r1 !== 1'b1 || c1 !== 2'd0 || c0 !== 8'd0) begin
            n_bad++;
            $display("FAIL clr_vs_rise got rise=%b cnt=%0d cnt8=%0d want 1/0/0", r1, c1, c0);
        end
        a = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_deb1();
        a = 1'b0;
        repeat (12) @(negedge clk);
        a = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            n_cmp++;
            if (y2 !== (e >= 3)) begin
                n_bad++;
                $display("FAIL deb1_step edge=%0d got y=%b want %b", e, y2, (e >= 3));
            end
        end
        repeat (12) @(negedge clk);
        a = 1'b0;
        repeat (12) @(negedge clk);
        a = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            a = 1'b0;
            n_cmp++;
            if (y2 !== (e == 3) || r2 !== (e == 3) || f2 !== (e == 4)) begin
                n_bad++;
                $display("FAIL deb1_pulse edge=%0d got y/r/f=%b%b%b want %b%b%b",
                         e, y2, r2, f2, (e == 3), (e == 3), (e == 4));
            end
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if ({y0, r0, f0} !== {my[0][0], mr[0][0], mf[0][0]} || c0 !== 8'(mc[0])) begin
                n_bad++;
                $display("FAIL rand_default cyc=%0d got y/r/f=%b%b%b cnt=%0d want %0d%0d%0d cnt=%0d",
                         cyc, y0, r0, f0, c0, my[0], mr[0], mf[0], mc[0]);
            end
            n_cmp++;
            if ({y1, r1, f1} !== {my[1][0], mr[1][0], mf[1][0]} || c1 !== 2'(mc[1])) begin
                n_bad++;
                $display("FAIL rand_cnt2 cyc=%0d got y/r/f=%b%b%b cnt=%0d want %0d%0d%0d cnt=%0d",
                         cyc, y1, r1, f1, c1, my[1], mr[1], mf[1], mc[1]);
            end
            n_cmp++;
            if ({y2, r2, f2} !== {my[2][0], mr[2][0], mf[2][0]} || c2 !== 8'(mc[2])) begin
                n_bad++;
                $display("FAIL rand_deb1 cyc=%0d got y/r/f=%b%b%b cnt=%0d want %0d%0d%0d cnt=%0d",
                         cyc, y2, r2, f2, c2, my[2], mr[2], mf[2], mc[2]);
            end
            if ($urandom_range(0, 5) == 0) a = ~a;
            clr = ($urandom_range(0, 29) == 0);
        end
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a   = 1'b1;
        clr = 1'b0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_reset_mid();
        test_wrap_clear();
        test_deb1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
